// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan driver: FSM states,
// all-off values and active-low segment patterns (bit0 = a .. bit6 = g).
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  // Active-low one-hot anode enable for a digit index.
  function automatic logic [3:0] anode_sel_n(input logic [1:0] idx);
    anode_sel_n = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low 7-segment pattern; codes 10..15 go dark.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_n_o
);

  // Pattern lookup for the currently selected digit.
  always_comb begin
    seg_n_o = SEG_OFF;
    case (bcd_i)
      4'd0:    seg_n_o = SEG_0;
      4'd1:    seg_n_o = SEG_1;
      4'd2:    seg_n_o = SEG_2;
      4'd3:    seg_n_o = SEG_3;
      4'd4:    seg_n_o = SEG_4;
      4'd5:    seg_n_o = SEG_5;
      4'd6:    seg_n_o = SEG_6;
      4'd7:    seg_n_o = SEG_7;
      4'd8:    seg_n_o = SEG_8;
      4'd9:    seg_n_o = SEG_9;
      default: seg_n_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit common-anode display driver with all-off dead time on
// every selector change. Optional build macro: LEADING_ZERO_BLANK_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  selectorBus,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_sel,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        busy
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [3:0]        sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        an_n_q, an_n_d;
  logic [6:0]        seg_n_q, seg_n_d;
  logic              dp_n_q, dp_n_d;
  logic              busy_q, busy_d;

  logic              change_s;
  logic              sel_valid_s;
  logic [1:0]        sel_idx_s;
  logic [3:0]        digit_s;
  logic [6:0]        dec_seg_s;
  logic              lz_blank_s;
  logic [3:0]        drv_an_s;
  logic [6:0]        drv_seg_s;
  logic              drv_dp_s;

  assign change_s    = (selectorBus != sel_q);
  assign sel_valid_s = (sel_q[3:2] == 2'b00);
  assign sel_idx_s   = sel_q[1:0];
  assign digit_s     = digits[{sel_idx_s, 2'b00} +: 4];

  bcd_to_seg u_dec (
    .bcd_i   (digit_s),
    .seg_n_o (dec_seg_s)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit above 0 goes dark when it and every higher digit are zero.
  always_comb begin
    lz_blank_s = 1'b0;
    case (sel_idx_s)
      2'd1:    lz_blank_s = (digits[15:4]  == 12'd0);
      2'd2:    lz_blank_s = (digits[15:8]  == 8'd0);
      2'd3:    lz_blank_s = (digits[15:12] == 4'd0);
      default: lz_blank_s = 1'b0;
    endcase
  end
`else
  assign lz_blank_s = 1'b0;
`endif

  // Output values for the DRIVE state, derived from the latched selector.
  always_comb begin
    drv_an_s  = AN_OFF;
    drv_seg_s = SEG_OFF;
    drv_dp_s  = 1'b1;
    if (sel_valid_s) begin
      drv_an_s  = anode_sel_n(sel_idx_s);
      drv_seg_s = lz_blank_s ? SEG_OFF : dec_seg_s;
      drv_dp_s  = ~dp_sel[sel_idx_s];
    end else begin
      drv_an_s  = AN_OFF;
      drv_seg_s = SEG_OFF;
      drv_dp_s  = 1'b1;
    end
  end

  // Next-state and registered-output logic; a selector change wins in any state.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    an_n_d  = an_n_q;
    seg_n_d = seg_n_q;
    dp_n_d  = dp_n_q;
    busy_d  = busy_q;
    if (change_s) begin
      sel_d   = selectorBus;
      cnt_d   = CNT_RELOAD;
      state_d = BLANK;
      an_n_d  = AN_OFF;
      seg_n_d = SEG_OFF;
      dp_n_d  = 1'b1;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          an_n_d  = AN_OFF;
          seg_n_d = SEG_OFF;
          dp_n_d  = 1'b1;
          busy_d  = 1'b0;
        end
        BLANK: begin
          if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            state_d = DRIVE;
            busy_d  = 1'b0;
            an_n_d  = drv_an_s;
            seg_n_d = drv_seg_s;
            dp_n_d  = drv_dp_s;
          end
        end
        DRIVE: begin
          an_n_d  = drv_an_s;
          seg_n_d = drv_seg_s;
          dp_n_d  = drv_dp_s;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = IDLE;
          an_n_d  = AN_OFF;
          seg_n_d = SEG_OFF;
          dp_n_d  = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 4'hF;
      cnt_q   <= CNT_ZERO;
      an_n_q  <= AN_OFF;
      seg_n_q <= SEG_OFF;
      dp_n_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      an_n_q  <= an_n_d;
      seg_n_q <= seg_n_d;
      dp_n_q  <= dp_n_d;
      busy_q  <= busy_d;
    end
  end

  assign an_n  = an_n_q;
  assign seg_n = seg_n_q;
  assign dp_n  = dp_n_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: directed vector table plus
// randomized traffic checked against a cycle-age reference model.
module tb_seg_scan_driver;

  localparam int BLANK = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ0 = 7'h7F;
`else
  localparam logic [6:0] LZ0 = 7'h40;
`endif

  localparam logic [6:0] SEG_REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  logic        clk;
  logic        rst;
  logic [3:0]  selectorBus;
  logic [15:0] digits;
  logic [3:0]  dp_sel;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        busy;

  seg_scan_driver #(.BLANK_CYCLES(BLANK), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .selectorBus (selectorBus),
    .digits      (digits),
    .dp_sel      (dp_sel),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          r;
    logic [3:0]  sel;
    logic [15:0] dig;
    logic [3:0]  dp;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dpn;
    logic        bsy;
  } vec_t;

  vec_t vq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: selector held, age in cycles since last change.
  int   m_sel    = 15;
  int   m_age    = 0;
  bit   m_active = 1'b0;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  logic       e_busy;

  function automatic void model(input bit r, input logic [3:0] s,
                                input logic [15:0] d, input logic [3:0] p);
    int dig;
    if (r) begin
      m_sel = 15; m_active = 1'b0;
    end else if (int'(s) != m_sel) begin
      m_sel = int'(s); m_age = 0; m_active = 1'b1;
    end else if (m_active) begin
      m_age++;
    end
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_busy = 1'b0;
    if (m_active && m_age < BLANK) begin
      e_busy = 1'b1;
    end else if (m_active && m_sel < 4) begin
      dig   = int'((d >> (4 * m_sel)) & 16'h000F);
      e_an  = 4'hF ^ (4'b0001 << m_sel);
      e_seg = SEG_REF[dig];
`ifdef LEADING_ZERO_BLANK_EN
      if (m_sel > 0 && (d >> (4 * m_sel)) == 16'h0000) e_seg = 7'h7F;
`endif
      e_dp  = ~p[m_sel];
    end
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input bit r, input logic [3:0] s,
                       input logic [15:0] d, input logic [3:0] p);
    rst = r; selectorBus = s; digits = d; dp_sel = p;
    @(posedge clk);
    model(r, s, d, p);
    #1;
  endtask

  function automatic void add(input bit r, input logic [3:0] s, input logic [15:0] d,
                              input logic [3:0] p, input logic [3:0] a,
                              input logic [6:0] g, input logic dn, input logic b);
    vec_t v;
    v.r = r; v.sel = s; v.dig = d; v.dp = p;
    v.an = a; v.seg = g; v.dpn = dn; v.bsy = b;
    vq.push_back(v);
  endfunction

  function automatic void blank(input int n, input logic [3:0] s,
                                input logic [15:0] d, input logic [3:0] p);
    for (int i = 0; i < n; i++) add(1'b0, s, d, p, 4'hF, 7'h7F, 1'b1, 1'b1);
  endfunction

  initial begin
    logic [3:0]  rs;
    logic [15:0] rd;
    logic [3:0]  rp;
    bit          rr;

    // Directed sequence, one entry per clock edge.
    add(1'b1, 4'd0, 16'h1234, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0);
    blank(4, 4'd0, 16'h1234, 4'h0);
    add(1'b0, 4'd0, 16'h1234, 4'h0, 4'b1110, 7'h19, 1'b1, 1'b0);
    blank(4, 4'd2, 16'h1234, 4'h0);
    add(1'b0, 4'd2, 16'h1234, 4'h0, 4'b1011, 7'h24, 1'b1, 1'b0);
    blank(4, 4'd3, 16'h1234, 4'h0);
    add(1'b0, 4'd3, 16'h1234, 4'h0, 4'b0111, 7'h79, 1'b1, 1'b0);
    blank(2, 4'd0, 16'h1234, 4'h0);
    blank(2, 4'd1, 16'h1234, 4'h0);
    blank(4, 4'd2, 16'h1234, 4'h0);
    add(1'b0, 4'd2, 16'h1234, 4'h0, 4'b1011, 7'h24, 1'b1, 1'b0);
    blank(1, 4'd3, 16'h1234, 4'h0);
    blank(4, 4'd2, 16'h1234, 4'h0);
    add(1'b0, 4'd2, 16'h1234, 4'h0, 4'b1011, 7'h24, 1'b1, 1'b0);
    blank(4, 4'd9, 16'h1234, 4'h0);
    add(1'b0, 4'd9, 16'h1234, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0);
    blank(4, 4'd1, 16'h00A0, 4'h0);
    add(1'b0, 4'd1, 16'h00A0, 4'h0, 4'b1101, 7'h7F, 1'b1, 1'b0);
    add(1'b0, 4'd1, 16'h00A0, 4'b0010, 4'b1101, 7'h7F, 1'b0, 1'b0);
    add(1'b0, 4'd1, 16'h0050, 4'h0, 4'b1101, 7'h12, 1'b1, 1'b0);
    blank(4, 4'd3, 16'h0050, 4'h0);
    add(1'b0, 4'd3, 16'h0050, 4'h0, 4'b0111, LZ0, 1'b1, 1'b0);
    add(1'b0, 4'd3, 16'h0050, 4'b1000, 4'b0111, LZ0, 1'b0, 1'b0);
    blank(4, 4'd2, 16'h0050, 4'h0);
    add(1'b0, 4'd2, 16'h0050, 4'h0, 4'b1011, LZ0, 1'b1, 1'b0);
    blank(4, 4'd0, 16'h0050, 4'h0);
    add(1'b0, 4'd0, 16'h0050, 4'h0, 4'b1110, 7'h40, 1'b1, 1'b0);
    blank(2, 4'd1, 16'h0050, 4'h0);
    add(1'b1, 4'd1, 16'h0050, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0);
    blank(4, 4'd1, 16'h0050, 4'h0);
    add(1'b0, 4'd1, 16'h0050, 4'h0, 4'b1101, 7'h12, 1'b1, 1'b0);
    add(1'b1, 4'd1, 16'h0050, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0);
    add(1'b1, 4'hF, 16'h0050, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0);
    add(1'b0, 4'hF, 16'h0050, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0);
    add(1'b0, 4'hF, 16'h0050, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0);

    rst = 1'b1; selectorBus = 4'd0; digits = 16'h0000; dp_sel = 4'h0;
    @(negedge clk);

    foreach (vq[i]) begin
      apply(vq[i].r, vq[i].sel, vq[i].dig, vq[i].dp);
      check("dir_an",   i, {4'h0, an_n},  {4'h0, vq[i].an});
      check("dir_seg",  i, {1'b0, seg_n}, {1'b0, vq[i].seg});
      check("dir_dp",   i, {7'h00, dp_n}, {7'h00, vq[i].dpn});
      check("dir_busy", i, {7'h00, busy}, {7'h00, vq[i].bsy});
    end

    // Randomized traffic against the reference model.
    rs = 4'd0; rd = 16'h0000; rp = 4'h0;
    apply(1'b1, rs, rd, rp);
    for (int n = 0; n < 1500; n++) begin
      rr = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 3) == 0) rs = 4'($urandom_range(4, 15));
        else                           rs = 4'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < 4; k++)
          rd[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 3) == 0) rp = 4'($urandom_range(0, 15));
      apply(rr, rs, rd, rp);
      check("rnd_an",   n, {4'h0, an_n},  {4'h0, e_an});
      check("rnd_seg",  n, {1'b0, seg_n}, {1'b0, e_seg});
      check("rnd_dp",   n, {7'h00, dp_n}, {7'h00, e_dp});
      check("rnd_busy", n, {7'h00, busy}, {7'h00, e_busy});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
